// File: rtl/mvm_seq_pkg.sv
// Shared types and helpers for the MVM job sequencer: mode encoding, FSM states,
// burst kinds and the burst-length rule.
package mvm_seq_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_MV = 3'd1;
    localparam mode_t MODE_VM = 3'd2;
    localparam mode_t MODE_M  = 3'd3;
    localparam mode_t MODE_V  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PULSE,
        S_STREAM,
        S_START,
        S_WAIT_DONE,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    typedef enum logic {
        KIND_VEC,
        KIND_MAT
    } kind_t;

    function automatic int unsigned burst_len(input kind_t kind, input int unsigned k);
        return (kind == KIND_MAT) ? k * k : k;
    endfunction

    function automatic logic mode_legal(input mode_t m);
        return (m >= MODE_MV) && (m <= MODE_V);
    endfunction

    // Phase 0 of MV/M loads the matrix first; VM/V start with the vector.
    function automatic kind_t phase_kind(input mode_t m, input logic phase);
        if (!phase)
            return (m == MODE_MV || m == MODE_M) ? KIND_MAT : KIND_VEC;
        return (m == MODE_VM) ? KIND_MAT : KIND_VEC;
    endfunction

endpackage

// File: rtl/mvm_seq_buf.sv
// Small register file with independent write/read pointers; words are read
// back in write order. Pointers reset and clear, contents do not.
module mvm_seq_buf #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_inc,
    output logic [W-1:0] rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en)
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + AW'(1);
            if (rd_inc)
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr] <= wr_data;
    end

    assign rd_data = mem[rptr];

endmodule

// File: rtl/mvm_job_sequencer.sv
// Front-end controller for the MVM datapath: stages operand bursts, issues
// load/start pulses, captures the non-stallable result burst and drains it.
module mvm_job_sequencer #(
    parameter int K       = 4,
    parameter int B       = 8,
    parameter int TIMEOUT = 1500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [B-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*B-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err_mode,
    output logic                  err_timeout,
    output logic                  mvm_loadMatrix,
    output logic                  mvm_loadVector,
    output logic                  mvm_start,
    output logic signed [B-1:0]   mvm_data_in,
    input  logic                  mvm_done,
    input  logic signed [2*B-1:0] mvm_data_out
);

    import mvm_seq_pkg::*;

    localparam int DEPTH = K * K;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int WW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] K_LAST  = CW'(K - 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    state_t          state;
    mode_t           mode_q;
    logic            phase;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   wdog;
    kind_t           kind;
    logic [CW-1:0]   n_last;
    logic            more_phase;

    logic            stage_clr;
    logic            stage_wr;
    logic            stage_inc;
    logic [B-1:0]    stage_rd;
    logic            res_clr;
    logic            res_wr;
    logic            res_inc;
    logic [2*B-1:0]  res_rd;

    assign kind       = phase_kind(mode_q, phase);
    assign n_last     = CW'(burst_len(kind, K) - 1);
    assign more_phase = (mode_q == MODE_MV || mode_q == MODE_VM) && !phase;

    assign cmd_ready = (state == S_IDLE);
    assign in_ready  = (state == S_FILL);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DRAIN);
    assign out_last  = out_valid && (cnt == K_LAST);
    assign out_data  = out_valid ? res_rd : '0;

    // Staging read pointer runs one word ahead of the registered mvm_data_in.
    assign stage_clr = (cmd_ready && cmd_valid && mode_legal(cmd_mode))
                     || (state == S_STREAM && cnt == n_last && more_phase);
    assign stage_wr  = in_ready && in_valid;
    assign stage_inc = (state == S_PULSE) || (state == S_STREAM && cnt != n_last);

    assign res_clr = (state == S_WAIT_DONE) && mvm_done;
    assign res_wr  = (state == S_CAPTURE);
    assign res_inc = out_valid && out_ready;

    mvm_seq_buf #(.DEPTH(DEPTH), .W(B)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .clr     (stage_clr),
        .wr_en   (stage_wr),
        .wr_data (in_data),
        .rd_inc  (stage_inc),
        .rd_data (stage_rd)
    );

    mvm_seq_buf #(.DEPTH(K), .W(2 * B)) u_result (
        .clk     (clk),
        .reset   (reset),
        .clr     (res_clr),
        .wr_en   (res_wr),
        .wr_data (mvm_data_out),
        .rd_inc  (res_inc),
        .rd_data (res_rd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            mode_q         <= '0;
            phase          <= 1'b0;
            cnt            <= '0;
            wdog           <= '0;
            mvm_loadMatrix <= 1'b0;
            mvm_loadVector <= 1'b0;
            mvm_start      <= 1'b0;
            mvm_data_in    <= '0;
            err_mode       <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            mvm_loadMatrix <= 1'b0;
            mvm_loadVector <= 1'b0;
            mvm_start      <= 1'b0;
            err_mode       <= 1'b0;
            err_timeout    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        mode_q <= cmd_mode;
                        phase  <= 1'b0;
                        cnt    <= '0;
                        if (mode_legal(cmd_mode))
                            state <= S_FILL;
                        else
                            err_mode <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        if (cnt == n_last) begin
                            cnt   <= '0;
                            state <= S_PULSE;
                            if (kind == KIND_MAT)
                                mvm_loadMatrix <= 1'b1;
                            else
                                mvm_loadVector <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_PULSE: begin
                    mvm_data_in <= stage_rd;
                    state       <= S_STREAM;
                end
                S_STREAM: begin
                    if (cnt == n_last) begin
                        cnt <= '0;
                        if (more_phase) begin
                            phase <= 1'b1;
                            state <= S_FILL;
                        end else begin
                            mvm_start <= 1'b1;
                            state     <= S_START;
                        end
                    end else begin
                        cnt         <= cnt + CW'(1);
                        mvm_data_in <= stage_rd;
                    end
                end
                S_START: begin
                    wdog  <= '0;
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (mvm_done) begin
                        cnt   <= '0;
                        state <= S_CAPTURE;
                    end else if (wdog == WD_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                // Results arrive back-to-back and cannot be held off.
                S_CAPTURE: begin
                    if (cnt == K_LAST) begin
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (cnt == K_LAST) begin
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_job_sequencer.sv
// Directed bench for mvm_job_sequencer with a behavioural MVM stub that raises
// done five cycles after start and then streams four result words.
module tb_mvm_job_sequencer;

    localparam int K       = 4;
    localparam int B       = 8;
    localparam int TIMEOUT = 1500;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_mode = 3'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        err_mode;
    logic        err_timeout;
    logic        mvm_loadMatrix;
    logic        mvm_loadVector;
    logic        mvm_start;
    logic [7:0]  mvm_data_in;
    logic        mvm_done;
    logic [15:0] mvm_data_out;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          grab = 0;
    int          start_cyc = 0;
    int          to_cyc = 0;
    int          err_mode_n = 0;
    int          err_to_n = 0;
    int          overlap_n = 0;
    logic        clr_logs = 1'b0;
    int          ev_q[$];
    logic [7:0]  stream_q[$];
    logic [15:0] out_q[$];
    logic        last_q[$];

    logic        stub_en = 1'b1;
    logic [15:0] stub_res [4];
    logic [7:0]  exp_stream[$];
    logic [7:0]  mat_q[$];
    logic [7:0]  vec_q[$];

    always #5 clk = ~clk;

    mvm_job_sequencer #(.K(K), .B(B), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_mode       (cmd_mode),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .err_mode       (err_mode),
        .err_timeout    (err_timeout),
        .mvm_loadMatrix (mvm_loadMatrix),
        .mvm_loadVector (mvm_loadVector),
        .mvm_start      (mvm_start),
        .mvm_data_in    (mvm_data_in),
        .mvm_done       (mvm_done),
        .mvm_data_out   (mvm_data_out)
    );

    // Monitor: cycle count and log clearing on posedge, observation on negedge.
    always @(posedge clk or negedge clk) begin
        if (clk) begin
            cyc <= cyc + 1;
            if (clr_logs) begin
                ev_q.delete();
                stream_q.delete();
                out_q.delete();
                last_q.delete();
            end
        end else if (!reset) begin
            grab <= 0;
        end else begin
            if (grab > 0) begin
                stream_q.push_back(mvm_data_in);
                grab <= grab - 1;
            end
            if (mvm_loadMatrix) begin
                ev_q.push_back(1);
                grab <= K * K;
            end
            if (mvm_loadVector) begin
                ev_q.push_back(2);
                grab <= K;
            end
            if (mvm_start) begin
                ev_q.push_back(3);
                start_cyc <= cyc;
            end
            if (int'(mvm_loadMatrix) + int'(mvm_loadVector) + int'(mvm_start) > 1)
                overlap_n <= overlap_n + 1;
            if (err_mode)
                err_mode_n <= err_mode_n + 1;
            if (err_timeout) begin
                err_to_n <= err_to_n + 1;
                to_cyc   <= cyc;
            end
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                last_q.push_back(out_last);
            end
        end
    end

    initial begin
        mvm_done     = 1'b0;
        mvm_data_out = 16'd0;
        forever begin
            @(negedge clk);
            if (reset && mvm_start && stub_en) begin
                repeat (5) @(negedge clk);
                mvm_done = 1'b1;
                @(negedge clk);
                mvm_done = 1'b0;
                for (int i = 0; i < K; i++) begin
                    mvm_data_out = stub_res[i];
                    @(negedge clk);
                end
                mvm_data_out = 16'd0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=sim_time_exceeded exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ev_code();
        int c = 0;
        foreach (ev_q[i]) c = c * 10 + ev_q[i];
        return c;
    endfunction

    task automatic clear_logs();
        clr_logs = 1'b1;
        @(negedge clk);
        clr_logs = 1'b0;
        exp_stream.delete();
        mat_q.delete();
        vec_q.delete();
    endtask

    task automatic send_cmd(input logic [2:0] m);
        cmd_mode  = m;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [7:0] w[$], input bit gap);
        foreach (w[i]) begin
            int wait_n;
            wait_n   = 0;
            in_data  = w[i];
            in_valid = 1'b1;
            while (!in_ready && wait_n < 200) begin
                @(negedge clk);
                wait_n++;
            end
            @(negedge clk);
            if (gap) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget);
        int c;
        c = 0;
        while (out_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
    endtask

    task automatic check_job(input string tag, input int ev_exp);
        check_eq({tag, "_events"}, ev_code(), ev_exp);
        check_eq({tag, "_stream_n"}, stream_q.size(), exp_stream.size());
        foreach (exp_stream[i])
            if (i < stream_q.size())
                check_eq($sformatf("%s_in%0d", tag, i), {24'd0, stream_q[i]}, {24'd0, exp_stream[i]});
        check_eq({tag, "_out_n"}, out_q.size(), K);
        for (int i = 0; i < K; i++) begin
            if (i < out_q.size()) begin
                check_eq($sformatf("%s_out%0d", tag, i), {16'd0, out_q[i]}, {16'd0, stub_res[i]});
                check_eq($sformatf("%s_last%0d", tag, i), {31'd0, last_q[i]}, {31'd0, (i == K - 1)});
            end
        end
        check_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int bad_modes [4];
        int c;
        int stall_bad;
        bad_modes = '{0, 5, 6, 7};

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ctl", {26'd0, in_ready, out_valid, out_last, err_mode, err_timeout, mvm_start}, 32'd0);
        check_eq("rst_loads", {30'd0, mvm_loadMatrix, mvm_loadVector}, 32'd0);
        check_eq("rst_data", {8'd0, out_data, mvm_data_in}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Mode 3, identity matrix, in_valid held high
        clear_logs();
        for (int i = 0; i < 16; i++) mat_q.push_back((i % 5 == 0) ? 8'd1 : 8'd0);
        exp_stream = mat_q;
        stub_res = '{16'd10, 16'd20, 16'd30, 16'd40};
        send_cmd(3'd3);
        check_eq("m3_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("m3_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        feed(mat_q, 1'b0);
        wait_outs(K, 400);
        check_job("m3", 13);

        // Mode 1 with in_valid toggling; signed boundary operands and results
        clear_logs();
        for (int i = 0; i < 16; i++) mat_q.push_back(8'(i * 29 - 120));
        vec_q.push_back(8'h80);
        vec_q.push_back(8'h7F);
        vec_q.push_back(8'hFF);
        vec_q.push_back(8'h01);
        foreach (mat_q[i]) exp_stream.push_back(mat_q[i]);
        foreach (vec_q[i]) exp_stream.push_back(vec_q[i]);
        stub_res = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
        send_cmd(3'd1);
        feed(mat_q, 1'b1);
        feed(vec_q, 1'b1);
        wait_outs(K, 400);
        check_job("m1", 123);

        // Illegal modes
        for (int j = 0; j < 4; j++) begin
            clear_logs();
            cmd_mode  = 3'(bad_modes[j]);
            cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            check_eq($sformatf("bad%0d_err_pulse", bad_modes[j]), {31'd0, err_mode}, 32'd1);
            check_eq($sformatf("bad%0d_cmd_ready", bad_modes[j]), {31'd0, cmd_ready}, 32'd1);
            @(negedge clk);
            check_eq($sformatf("bad%0d_err_drop", bad_modes[j]), {31'd0, err_mode}, 32'd0);
            repeat (5) @(negedge clk);
            check_eq($sformatf("bad%0d_no_mvm", bad_modes[j]), ev_code(), 0);
            check_eq($sformatf("bad%0d_busy", bad_modes[j]), {31'd0, busy}, 32'd0);
        end
        check_eq("err_mode_total", err_mode_n, 4);

        // Watchdog: stub never answers
        clear_logs();
        stub_en = 1'b0;
        for (int i = 0; i < 4; i++) vec_q.push_back(8'(i + 1));
        send_cmd(3'd4);
        feed(vec_q, 1'b0);
        c = 0;
        while (err_to_n < 1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check_eq("to_pulse_n", err_to_n, 1);
        check_eq("to_delay", to_cyc - start_cyc, TIMEOUT + 1);
        check_eq("to_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("to_pulse_once", err_to_n, 1);
        check_eq("to_no_out", out_q.size(), 0);
        check_eq("to_events", ev_code(), 23);

        // Mode 4 after the abort completes normally
        clear_logs();
        stub_en = 1'b1;
        vec_q.push_back(8'hFB);
        vec_q.push_back(8'h06);
        vec_q.push_back(8'hF9);
        vec_q.push_back(8'h08);
        exp_stream = vec_q;
        stub_res = '{16'hFFF1, 16'h0002, 16'hFFE3, 16'h0004};
        send_cmd(3'd4);
        feed(vec_q, 1'b0);
        wait_outs(K, 400);
        check_job("m4", 23);

        // Consumer stalls for 20 cycles in DRAIN
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) mat_q.push_back(8'(i + 1));
        exp_stream = mat_q;
        stub_res = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0};
        send_cmd(3'd3);
        feed(mat_q, 1'b0);
        c = 0;
        while (!out_valid && c < 400) begin
            @(negedge clk);
            c++;
        end
        check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
        stall_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_data !== stub_res[0] || out_valid !== 1'b1) stall_bad++;
        end
        check_eq("stall_hold", stall_bad, 0);
        check_eq("stall_none_taken", out_q.size(), 0);
        out_ready = 1'b1;
        wait_outs(K, 100);
        check_job("stall", 13);

        // Reset while streaming, then mode 2
        clear_logs();
        for (int i = 0; i < 16; i++) mat_q.push_back(8'h55 ^ 8'(i));
        send_cmd(3'd3);
        feed(mat_q, 1'b0);
        c = 0;
        while (ev_q.size() < 1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("mrst_busy", {31'd0, busy}, 32'd0);
        check_eq("mrst_ctl", {26'd0, in_ready, out_valid, out_last, err_mode, err_timeout, mvm_start}, 32'd0);
        check_eq("mrst_loads", {30'd0, mvm_loadMatrix, mvm_loadVector}, 32'd0);
        check_eq("mrst_data", {8'd0, out_data, mvm_data_in}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        clear_logs();
        vec_q.push_back(8'h11);
        vec_q.push_back(8'h22);
        vec_q.push_back(8'h33);
        vec_q.push_back(8'h44);
        for (int i = 0; i < 16; i++) mat_q.push_back(8'hA0 + 8'(i));
        foreach (vec_q[i]) exp_stream.push_back(vec_q[i]);
        foreach (mat_q[i]) exp_stream.push_back(mat_q[i]);
        stub_res = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        send_cmd(3'd2);
        feed(vec_q, 1'b0);
        feed(mat_q, 1'b0);
        wait_outs(K, 400);
        check_job("m2", 213);

        check_eq("no_pulse_overlap", overlap_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
